// File: rtl/sa_tile_sched.sv
// rtl/sa_tile_sched.sv - systolic tile scheduler: weight load, skewed activation stream, drain
// Optional feature macro: SA_SCHED_PERF_EN (adds perf_busy / perf_stall counters)
module sa_tile_sched #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int KMAX = 256,
  parameter int KW   = $clog2(KMAX + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            w_valid,
  output logic            w_rd,
  input  logic            a_valid,
  output logic            a_rd,
  output logic            fire,
  output logic [ROWS-1:0] row_en,
  input  logic            out_space,
  output logic            busy,
  output logic            done
`ifdef SA_SCHED_PERF_EN
  ,
  output logic [31:0]     perf_busy,
  output logic [31:0]     perf_stall
`endif
);

  // Counter must reach the longest phase: k_q+ROWS-2 stream steps or ROWS+COLS-2 drain steps.
  localparam int CW = $clog2(KMAX + ROWS + COLS + 1);
  localparam logic [CW-1:0] LOAD_LAST  = CW'(ROWS - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(ROWS + COLS - 2);
  localparam logic [KW-1:0] KMAX_K     = KW'(KMAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [KW-1:0] k_q, k_q_nx;
  logic [KW-1:0] k_clamp;
  logic [CW-1:0] k_ext;
  logic [CW-1:0] stream_last;

  assign k_clamp     = (k_len > KMAX_K) ? KMAX_K : k_len;
  assign k_ext       = CW'(k_q);
  assign stream_last = k_ext + CW'(ROWS - 2);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // State, counter and latched tile length registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      k_q   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      k_q   <= k_q_nx;
    end
  end

  // Next-state logic and the combinational pop / fire / skew-mask outputs
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    k_q_nx   = k_q;
    w_rd     = 1'b0;
    a_rd     = 1'b0;
    fire     = 1'b0;
    row_en   = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          k_q_nx   = k_clamp;
          cnt_nx   = '0;
          state_nx = (k_clamp == '0) ? S_DONE : S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        w_rd = w_valid;
        if (w_valid) begin
          if (cnt == LOAD_LAST) begin
            state_nx = S_STREAM;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      S_STREAM: begin
        // Past the last vector the array only needs flushing steps, so no a_valid is required.
        fire = (cnt >= k_ext) || a_valid;
        a_rd = fire && (cnt < k_ext);
        // Row r sees vector (t - r): rows enter the wavefront one step apart.
        for (int r = 0; r < ROWS; r++) begin
          row_en[r] = fire && (cnt >= CW'(r)) && (cnt < CW'(r) + k_ext);
        end
        if (fire) begin
          if (cnt == stream_last) begin
            state_nx = S_DRAIN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        fire = out_space;
        if (fire) begin
          if (cnt == DRAIN_LAST) begin
            state_nx = S_DONE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

`ifdef SA_SCHED_PERF_EN
  logic active;
  assign active = (state == S_LOAD_W) || (state == S_STREAM) || (state == S_DRAIN);

  // Saturating activity / stall counters, cleared at tile start and held after completion
  always_ff @(posedge clk) begin
    if (rst || ((state == S_IDLE) && start)) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else if (active) begin
      if (perf_busy != '1) perf_busy <= perf_busy + 1'b1;
      if (!w_rd && !fire && (perf_stall != '1)) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sa_tile_sched.sv
// tb/tb_sa_tile_sched.sv - self-checking bench for sa_tile_sched
`timescale 1ns/1ps
module tb_sa_tile_sched;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int KMAX = 256;
  localparam int KW   = $clog2(KMAX + 1);

  logic            clk = 1'b0;
  logic            rst, start, w_valid, a_valid, out_space;
  logic [KW-1:0]   k_len;
  logic            w_rd, a_rd, fire, busy, done;
  logic [ROWS-1:0] row_en;
`ifdef SA_SCHED_PERF_EN
  logic [31:0]     perf_busy, perf_stall;
`endif

  always #5 clk = ~clk;

  sa_tile_sched #(.ROWS(ROWS), .COLS(COLS), .KMAX(KMAX)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .w_valid(w_valid), .w_rd(w_rd), .a_valid(a_valid), .a_rd(a_rd),
    .fire(fire), .row_en(row_en), .out_space(out_space),
    .busy(busy), .done(done)
`ifdef SA_SCHED_PERF_EN
    , .perf_busy(perf_busy), .perf_stall(perf_stall)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s_cyc = 0;
  int n_w = 0, n_a = 0, n_f = 0, n_done = 0, done_cyc = -1;
  int b_w, b_a, b_f, b_d;
  logic [ROWS-1:0] rowlog [64];

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: counts pops/fires, records done time and row_en per cycle since launch
  always @(negedge clk) begin
    if (w_rd === 1'b1) n_w++;
    if (a_rd === 1'b1) n_a++;
    if (fire === 1'b1) n_f++;
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    if ((cyc - s_cyc) >= 0 && (cyc - s_cyc) < 64) rowlog[cyc - s_cyc] = row_en;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int k);
    b_w = n_w; b_a = n_a; b_f = n_f; b_d = n_done; s_cyc = cyc;
    start = 1'b1;
    k_len = KW'(k);
    step();
    start = 1'b0;
    k_len = KW'($urandom_range(0, 511));
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (n_done == b_d && i < budget) begin
      step();
      i++;
    end
    chk("done_seen", 64'(n_done != b_d), 64'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_fire"}, 64'(fire), 64'd0);
    chk({tag, "_w_rd"}, 64'(w_rd), 64'd0);
    chk({tag, "_a_rd"}, 64'(a_rd), 64'd0);
    chk({tag, "_row_en"}, 64'(row_en), 64'd0);
  endtask

  typedef struct {
    int k;
    int lat;
    int nw;
    int na;
    int nf;
  } vec_t;
  vec_t tbl [6];

  // Reference model state (transfer counts per phase)
  bit m_busy, m_done, ph_load, ph_strm, ph_drn, e_w, e_f, e_a;
  int wc, sc, dc, mk, pb, ps;
  logic [ROWS-1:0] e_row;

  initial begin
    // No-stall tile totals: latency = 1 + ROWS + (k+ROWS-1) + (ROWS+COLS-1)
    tbl[0] = '{4,   35,  8, 4,   26};
    tbl[1] = '{0,   1,   0, 0,   0};
    tbl[2] = '{1,   32,  8, 1,   23};
    tbl[3] = '{256, 287, 8, 256, 278};
    tbl[4] = '{300, 287, 8, 256, 278};
    tbl[5] = '{9,   40,  8, 9,   31};

    rst = 1'b1; start = 1'b0; k_len = '0;
    w_valid = 1'b1; a_valid = 1'b1; out_space = 1'b1;
    step(); step();
    @(negedge clk);
    chk_idle_outputs("reset");
`ifdef SA_SCHED_PERF_EN
    chk("reset_perf_busy", 64'(perf_busy), 64'd0);
    chk("reset_perf_stall", 64'(perf_stall), 64'd0);
`endif
    step();
    rst = 1'b0;
    step();

    // Table: back-to-back tiles with all inputs valid
    for (int i = 0; i < 6; i++) begin
      launch(tbl[i].k);
      wait_done(400);
      chk($sformatf("tbl%0d_latency", i), 64'(done_cyc - s_cyc), 64'(tbl[i].lat));
      chk($sformatf("tbl%0d_w_rd", i), 64'(n_w - b_w), 64'(tbl[i].nw));
      chk($sformatf("tbl%0d_a_rd", i), 64'(n_a - b_a), 64'(tbl[i].na));
      chk($sformatf("tbl%0d_fire", i), 64'(n_f - b_f), 64'(tbl[i].nf));
    end

    // Skew mask for k=4: STREAM t=0 is cycle 9 after start
    launch(4);
    wait_done(100);
    chk("row_en_load_last", 64'(rowlog[8]), 64'h00);
    chk("row_en_t0", 64'(rowlog[9]), 64'h01);
    chk("row_en_t3", 64'(rowlog[12]), 64'h0f);
    chk("row_en_t10", 64'(rowlog[19]), 64'h80);

    // a_valid dropped for 3 cycles at STREAM t=2
    launch(4);
    repeat (10) step();
    a_valid = 1'b0;
    repeat (3) step();
    a_valid = 1'b1;
    wait_done(100);
    chk("astall_latency", 64'(done_cyc - s_cyc), 64'd38);
    chk("astall_a_rd", 64'(n_a - b_a), 64'd4);
    chk("astall_fire", 64'(n_f - b_f), 64'd26);
    chk("astall_row_en_stalled", 64'(rowlog[11] | rowlog[12] | rowlog[13]), 64'h00);
    chk("astall_row_en_resume_t2", 64'(rowlog[14]), 64'h07);
`ifdef SA_SCHED_PERF_EN
    chk("astall_perf_busy", 64'(perf_busy), 64'd37);
    chk("astall_perf_stall", 64'(perf_stall), 64'd3);
`endif

    // out_space low for 5 cycles mid-DRAIN, with start asserted in that window
    launch(4);
    repeat (24) step();
    out_space = 1'b0;
    start = 1'b1;
    k_len = KW'(5);
    repeat (5) step();
    out_space = 1'b1;
    start = 1'b0;
    wait_done(100);
    chk("ospace_latency", 64'(done_cyc - s_cyc), 64'd40);
    chk("ospace_fire", 64'(n_f - b_f), 64'd26);
    @(negedge clk);
    chk("ospace_idle_after", 64'(busy), 64'd0);
`ifdef SA_SCHED_PERF_EN
    chk("ospace_perf_busy", 64'(perf_busy), 64'd39);
    chk("ospace_perf_stall", 64'(perf_stall), 64'd5);
`endif
    step();

    // start held through the DONE cycle of a k=0 tile must not restart
    b_d = n_done;
    start = 1'b1;
    k_len = '0;
    step();
    step();
    start = 1'b0;
    @(negedge clk);
    chk("start_in_done_ignored", 64'(busy), 64'd0);
    chk("k0_done_count", 64'(n_done - b_d), 64'd1);
    step();

    // Reset pulsed at STREAM t=5 aborts without done
    launch(4);
    repeat (13) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("abort");
    repeat (40) step();
    chk("abort_no_done", 64'(n_done - b_d), 64'd0);
    launch(4);
    wait_done(100);
    chk("after_abort_latency", 64'(done_cyc - s_cyc), 64'd35);
    step();

    // Randomized traffic against the transfer-count reference model
    m_busy = 0; m_done = 0; wc = 0; sc = 0; dc = 0; mk = 0; pb = 0; ps = 0;
    for (int c = 0; c < 6000; c++) begin
      rst       = (c == 0) || ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 3) == 0);
      k_len     = ($urandom_range(0, 15) == 0) ? KW'($urandom_range(0, 511)) : KW'($urandom_range(0, 12));
      w_valid   = ($urandom_range(0, 3) != 0);
      a_valid   = ($urandom_range(0, 3) != 0);
      out_space = ($urandom_range(0, 3) != 0);

      ph_load = m_busy && !m_done && (wc < ROWS);
      ph_strm = m_busy && !m_done && (wc >= ROWS) && (sc < mk + ROWS - 1);
      ph_drn  = m_busy && !m_done && (wc >= ROWS) && (sc >= mk + ROWS - 1);
      e_w = ph_load && w_valid;
      e_f = (ph_strm && ((sc >= mk) || a_valid)) || (ph_drn && out_space);
      e_a = ph_strm && e_f && (sc < mk);
      e_row = '0;
      for (int r = 0; r < ROWS; r++) begin
        if (ph_strm && e_f && (sc - r) >= 0 && (sc - r) < mk) e_row[r] = 1'b1;
      end

      @(negedge clk);
      chk("rnd_busy", 64'(busy), 64'(m_busy));
      chk("rnd_done", 64'(done), 64'(m_done));
      chk("rnd_w_rd", 64'(w_rd), 64'(e_w));
      chk("rnd_a_rd", 64'(a_rd), 64'(e_a));
      chk("rnd_fire", 64'(fire), 64'(e_f));
      chk("rnd_row_en", 64'(row_en), 64'(e_row));
`ifdef SA_SCHED_PERF_EN
      chk("rnd_perf_busy", 64'(perf_busy), 64'(pb));
      chk("rnd_perf_stall", 64'(perf_stall), 64'(ps));
`endif
      step();

      if (rst) begin
        m_busy = 0; m_done = 0; pb = 0; ps = 0;
      end else if (m_done) begin
        m_done = 0; m_busy = 0;
      end else if (!m_busy) begin
        if (start) begin
          mk = (k_len > KMAX) ? KMAX : int'(k_len);
          wc = 0; sc = 0; dc = 0; pb = 0; ps = 0;
          m_busy = 1;
          m_done = (mk == 0);
        end
      end else begin
        pb++;
        if (!e_w && !e_f) ps++;
        if (e_w) wc++;
        if (ph_strm && e_f) sc++;
        if (ph_drn && e_f) begin
          dc++;
          if (dc == ROWS + COLS - 1) m_done = 1;
        end
      end
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_tile_sched.md
# sa_tile_sched

Tile scheduler for the systolic PE array: it sequences one matrix-multiply tile through weight load, skewed activation streaming and result drain. It sits between the weight/activation input buffers and the PE array, and drives the array's `fire` advance strobe and per-row feed enables. It also holds the array during drain until the column output controller has space, then signals tile completion.

## Interface
Parameters:
- `ROWS`, 8: PE array rows; also the number of weight rows loaded per tile.
- `COLS`, 8: PE array columns.
- `KMAX`, 256: maximum activation vectors per tile.
- `KW`, `$clog2(KMAX+1)`: width of `k_len`.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  begin a tile; sampled only in IDLE.
- `k_len`  in  KW  activation vector count; latched when `start` is accepted.
- `w_valid`  in  1  weight buffer holds a row.
- `w_rd`  out  1  pop a weight row; also serves as the PE weight-capture strobe.
- `a_valid`  in  1  activation buffer holds a vector.
- `a_rd`  out  1  pop an activation vector.
- `fire`  out  1  advance the PE array one step.
- `row_en`  out  ROWS  per-row activation feed enable (skew mask).
- `out_space`  in  1  output controller can accept drained results.
- `busy`  out  1  tile in progress.
- `done`  out  1  one-cycle tile-complete pulse.

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- Registers: state; `k_q` (latched length); `cnt` (shared step counter, zeroed on every state entry).
- IDLE, `start`=1:
  - latch `k_q` = min(`k_len`, KMAX);
  - if `k_q`==0, go to DONE;
  - otherwise go to LOAD_W.
- `start` while not IDLE is ignored.
- LOAD_W:
  - `w_rd` = `w_valid`; `cnt` increments on each `w_rd`;
  - the transfer with `cnt`==ROWS-1 goes to STREAM;
  - `fire`=0 throughout.
- STREAM, step t=`cnt`, t = 0 .. `k_q`+ROWS-2:
  - the step may proceed when t ≥ `k_q` or `a_valid`=1;
  - `fire` = proceed; `a_rd` = `fire` and t < `k_q`;
  - `row_en[r]` = `fire` and r ≤ t < r+`k_q`;
  - `cnt` increments on `fire`; `fire` at t=`k_q`+ROWS-2 goes to DRAIN.
- DRAIN:
  - `fire` = `out_space`; `cnt` increments on `fire`;
  - after ROWS+COLS-1 fires, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `busy` = (state != IDLE), including the DONE cycle.
- `fire`, `w_rd`, `a_rd` and `row_en` are combinational from state, `cnt` and the current inputs. All other outputs are registered-state decodes.
- An input stall (`w_valid`=0 or `a_valid`=0) freezes `cnt`; no pop and no `fire` occur in a stalled cycle.

## Timing
- Reset values: all outputs 0; state IDLE; `cnt` 0; `k_q` 0. Reset mid-tile aborts immediately with no `done` pulse, and the next cycle behaves as IDLE.
- `start` accepted at cycle N: `busy`=1 from N+1; the first `w_rd` is possible at N+1.
- Cycle count with no stalls is 1+ROWS+(`k_q`+ROWS-1)+(ROWS+COLS-1), with `done` high on the last of those cycles.
- Example, ROWS=COLS=8, `k_len`=4: `start` at cycle 0, LOAD_W cycles 1–8, STREAM 9–19, DRAIN 20–34, `done` at cycle 35.
- `k_len`=0: `done` at N+1; no `w_rd`, `a_rd` or `fire` is issued.
- Back-to-back tiles: `start` in the cycle after `done` (IDLE) is accepted; `start` during the DONE cycle is ignored.
- `k_len` changes after acceptance have no effect on the tile in progress.

## Configuration
- `SA_SCHED_PERF_EN` defined: adds outputs `perf_busy` (32 bits) and `perf_stall` (32 bits).
  - `perf_busy` counts cycles spent in LOAD_W, STREAM or DRAIN.
  - `perf_stall` counts cycles in those states where no `w_rd` and no `fire` occurred.
  - Both clear to 0 on `start` acceptance and on `rst`; both hold their value after `done`; both saturate at all-ones.
- `SA_SCHED_PERF_EN` undefined: these ports and counters do not exist, and all other behaviour is identical.

## Test plan
- ROWS=COLS=8, `k_len`=4, inputs always valid, `out_space`=1 → 8 `w_rd`, 4 `a_rd`, 26 `fire`; `done` at cycle 35. `row_en` at t=0 is 8'b00000001, at t=3 is 8'b00001111, at t=10 is 8'b10000000.
- `k_len`=0 → `done` one cycle after `start`, with zero `w_rd`, `a_rd` and `fire`.
- `a_valid` dropped for 3 cycles at STREAM t=2 → `fire` and `a_rd` low for those 3 cycles, `cnt` frozen, `done` delayed by exactly 3 cycles.
- `out_space` low for 5 cycles mid-DRAIN → `fire` low for those cycles and `done` 5 cycles late. `start` asserted during that window is ignored.
- `rst` pulsed in STREAM at t=5 → next cycle all outputs 0 and no `done`. A fresh `start` then completes in the nominal cycle count.
- With `SA_SCHED_PERF_EN`, scenario 3 → `perf_busy`=37 (8 load + 11 stream + 15 drain + 3 stall cycles) and `perf_stall`=3.
